// File: rtl/rtc_bus_driver_if.sv
// Request/response and RTC chip pins of the RTC bus engine, grouped as one interface.
// The slave side is the bus engine; the master side is the sequencer plus chip pads.
interface rtc_bus_driver_if;
  // Request side: req is sampled at a clk edge and accepted only while busy=0.
  // we/addr/wdata are captured on that same edge. done pulses once per accepted request.
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;

  // Chip side
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  // Current FSM state, for debug and checkers
  logic [2:0] dbg_state;

  modport slave (
    input  req, we, addr, wdata, ad_in,
    output rdata, busy, done, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe, dbg_state
  );

  modport master (
    output req, we, addr, wdata, ad_in,
    input  rdata, busy, done, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe, dbg_state
  );
endinterface

// File: rtl/rtc_bus_driver.sv
// Multiplexed address/data strobe engine for the parallel RTC chip.
// It runs one transaction at a time, and every output comes directly from a flop.
module rtc_bus_driver #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 10,
  parameter int T_HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_STROBE,
    S_ADDR_HOLD,
    S_DATA_SETUP,
    S_DATA_STROBE,
    S_DATA_HOLD,
    S_DONE
  } state_e;

  // The phase counter is loaded with (duration - 1) and counts down to zero.
  localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       phase_end;

  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_n_q, ad_n_d;
  logic       ad_oe_q, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  assign phase_end = (cnt_q == 8'd0);

  // Next state, phase counter and request latches
  always_comb begin
    state_d = state_q;
    cnt_d   = phase_end ? 8'd0 : cnt_q - 8'd1;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (bus.req) begin
          state_d = S_ADDR_SETUP;
          cnt_d   = SETUP_LD;
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end
      end
      S_ADDR_SETUP: begin
        if (phase_end) begin
          state_d = S_ADDR_STROBE;
          cnt_d   = PULSE_LD;
        end
      end
      S_ADDR_STROBE: begin
        if (phase_end) begin
          state_d = S_ADDR_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_ADDR_HOLD: begin
        if (phase_end) begin
          state_d = S_DATA_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_DATA_SETUP: begin
        if (phase_end) begin
          state_d = S_DATA_STROBE;
          cnt_d   = PULSE_LD;
        end
      end
      S_DATA_STROBE: begin
        if (phase_end) begin
          state_d = S_DATA_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_DATA_HOLD: begin
        if (phase_end) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Read data is captured on the edge that ends the last read-strobe cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == S_DATA_STROBE && phase_end && !we_q) begin
      rdata_d = bus.ad_in;
    end
  end

  // Pin values are decoded from the state being entered, so each pin comes from a flop
  // and still changes on the same edge as the state.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'd0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    case (state_d)
      S_ADDR_SETUP, S_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_ADDR_STROBE: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = 1'b0;
      end
      S_DATA_SETUP, S_DATA_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = we_d;
        ad_out_d = we_d ? wdata_d : 8'd0;
      end
      S_DATA_STROBE: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = we_d;
        ad_out_d = we_d ? wdata_d : 8'd0;
        wr_n_d   = ~we_d;
        rd_n_d   = we_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ad_n_q   <= ad_n_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.ad_n      = ad_n_q;
  assign bus.ad_oe     = ad_oe_q;
  assign bus.ad_out    = ad_out_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Bench for rtc_bus_driver: directed scenarios plus random traffic against a
// cycle-index reference model of one transaction.
module tb_rtc_bus_driver;
  localparam int S = 2;
  localparam int P = 10;
  localparam int H = 2;
  localparam int L = S + P + H;

  logic clk = 1'b0;
  logic reset;

  rtc_bus_driver_if bus();

  rtc_bus_driver #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int last_done_cyc = -1;
  int prev_done_cyc = -1;

  // Reference model: k = cycle index since acceptance (0 = idle, 2L+1 = done cycle)
  int         k;
  logic       m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_we = 1'b0;
    m_addr = 8'd0;
    m_wdata = 8'd0;
    m_rdata = 8'd0;
    exp_q.delete();
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (k == 0) begin
      if (bus.req) begin
        k = 1;
        m_we = bus.we;
        m_addr = bus.addr;
        m_wdata = bus.wdata;
      end
    end else begin
      if (k == L + S + P && !m_we) m_rdata = bus.ad_in;
      if (k == 2 * L + 1) k = 0;
      else k++;
      if (k == 2 * L + 1) exp_q.push_back(m_rdata);
    end
  endtask

  // Scoreboard: compare every observable output with the model
  task automatic compare();
    logic       e_cs_n, e_rd_n, e_wr_n, e_ad_n, e_oe, e_busy, e_done;
    logic [7:0] e_out;
    logic [7:0] popped;
    logic       in_addr, in_data, data_strobe;
    in_addr     = (k >= 1 && k <= L);
    in_data     = (k > L && k <= 2 * L);
    data_strobe = (k > L + S && k <= L + S + P);
    e_cs_n = !(in_addr || in_data);
    e_ad_n = !in_addr;
    e_oe   = in_addr || (in_data && m_we);
    e_wr_n = !((k > S && k <= S + P) || (m_we && data_strobe));
    e_rd_n = !(!m_we && data_strobe);
    e_busy = (k != 0);
    e_done = (k == 2 * L + 1);
    e_out  = in_addr ? m_addr : m_wdata;
    check("ctl{cs,rd,wr,ad_n,oe,busy,done}",
          {25'd0, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_n, bus.ad_oe, bus.busy, bus.done},
          {25'd0, e_cs_n, e_rd_n, e_wr_n, e_ad_n, e_oe, e_busy, e_done});
    if (e_oe) check("ad_out", {24'd0, bus.ad_out}, {24'd0, e_out});
    check("rdata", {24'd0, bus.rdata}, {24'd0, m_rdata});
    check("rd_wr_excl", {31'd0, ~bus.rd_n & ~bus.wr_n}, 32'd0);
    if (bus.done === 1'b1) begin
      done_seen++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        popped = exp_q.pop_front();
        check("txn_rdata", {24'd0, bus.rdata}, {24'd0, popped});
      end
    end
  endtask

  // Driver tasks
  task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.req = r;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    model_step();
    #2 reset = 1'b1;
    model_reset();
    #1 compare();
    check("rst_ad_out", {24'd0, bus.ad_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc++;
    compare();
  endtask

  initial begin
    int c0, d0;
    reset = 1'b1;
    bus.ad_in = 8'd0;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare();
    check("rst_ad_out", {24'd0, bus.ad_out}, 32'd0);
    reset = 1'b0;

    // Write 0x21/0x45, with a stray req at E0+5 carrying a different address
    d0 = done_seen;
    drive(1'b1, 1'b1, 8'h21, 8'h45);
    step();
    c0 = cyc;
    drive(1'b0, 1'b1, 8'h21, 8'h45);
    run(4);
    drive(1'b1, 1'b0, 8'h99, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h99, 8'h00);
    run(30);
    check("wr_done_latency", last_done_cyc - c0, 28);
    check("wr_one_done", done_seen - d0, 1);

    // Read 0x22 with the chip returning 0x37
    bus.ad_in = 8'h37;
    drive(1'b1, 1'b0, 8'h22, 8'h00);
    step();
    c0 = cyc;
    drive(1'b0, 1'b0, 8'h22, 8'h00);
    run(30);
    check("rd_done_latency", last_done_cyc - c0, 28);
    check("rd_data_37", {24'd0, bus.rdata}, 32'h37);

    // Two back-to-back writes with req held high: DONE and one IDLE cycle between them
    drive(1'b1, 1'b1, 8'h10, 8'hA5);
    step();
    c0 = cyc;
    run(59);
    drive(1'b0, 1'b1, 8'h10, 8'hA5);
    run(3);
    check("b2b_first_done", prev_done_cyc - c0, 28);
    check("b2b_second_done", last_done_cyc - c0, 58);

    // Read aborted by reset during the data strobe, then a full rerun
    bus.ad_in = 8'h5C;
    drive(1'b1, 1'b0, 8'h22, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h22, 8'h00);
    run(L + S + 3);
    d0 = done_seen;
    async_reset_mid();
    run(35);
    check("abort_no_done", done_seen - d0, 0);
    drive(1'b1, 1'b0, 8'h22, 8'h00);
    step();
    c0 = cyc;
    drive(1'b0, 1'b0, 8'h22, 8'h00);
    run(30);
    check("rerun_done_latency", last_done_cyc - c0, 28);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_mid();
      end else begin
        drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        bus.ad_in = 8'($urandom_range(0, 255));
        step();
      end
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    run(2 * L + 4);
    check("final_idle", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
